dmem_access_ctrl: RTL and testbench

Sequences data-memory accesses for the MEM stage of the 5-stage MIPS pipeline. It takes the MemRead/MemWrite control bits, ALU address and store data held in the EX/MEM pipeline register, and issues a req/ack transaction to a variable-latency data memory. It stalls the pipeline until the access completes, returns load data to MEM/WB, and flags misaligned, illegal and timed-out accesses.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/dmem_access_ctrl_if.sv | 30 +++
 rtl/dmem_timeout_cnt.sv | 28 ++
 rtl/dmem_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage access FSM states, word alignment
// mask and EX/MEM MEM-field bit positions.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // EX/MEM register MEM control field layout
    localparam int unsigned EXMEM_M_MEMWRITE = 0;
    localparam int unsigned EXMEM_M_MEMREAD  = 1;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & ~WORD_ALIGN_MASK) != '0;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller
// (master) and the variable-latency data memory (slave).
interface dmem_access_ctrl_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/dmem_timeout_cnt.sv
// WAIT-state cycle counter: clear on request issue, count while waiting,
// flag the last permitted WAIT cycle.
module dmem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues req/ack transactions, stalls
// the pipeline until completion and flags misaligned, illegal and timed-out accesses.
module dmem_access_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         alu_addr,
    input  logic [31:0]         write_data,
    dmem_access_ctrl_if.master  dmem,
    output logic [31:0]         read_data_m,
    output logic                stall,
    output logic                align_err,
    output logic                illegal_err,
    output logic                timeout_err
);

    dmem_state_t state_q, state_d;

    logic        req_q,   req_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aerr_q,  aerr_d;
    logic        ierr_q,  ierr_d;
    logic        terr_q,  terr_d;
    logic        stall_c;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        cnt_tc;
    logic        access;

    assign access = mem_read | mem_write;

    dmem_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .tc      (cnt_tc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            aerr_q  <= 1'b0;
            ierr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            aerr_q  <= aerr_d;
            ierr_q  <= ierr_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        aerr_d  = 1'b0;
        ierr_d  = 1'b0;
        terr_d  = 1'b0;
        stall_c = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (mem_read && mem_write) begin
                        ierr_d = 1'b1;
                    end else if (is_misaligned(alu_addr)) begin
                        aerr_d = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = alu_addr & WORD_ALIGN_MASK;
                        wdata_d = write_data;
                        cnt_clr = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                // ack takes priority over a coincident timeout
                if (dmem.dmem_ack) begin
                    if (!we_q) begin
                        rdata_d = dmem.dmem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_tc) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    terr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // stall must read low while reset is held, even with an access pending
    assign stall       = reset_n & stall_c;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign read_data_m = rdata_q;
    assign align_err   = aerr_q;
    assign illegal_err = ierr_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized self-checking bench for dmem_access_ctrl against a per-transaction
// reference model (expected stall length, bus values, load result, error pulses).
module tb_dmem_access_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 5;

    logic        clock;
    logic        reset_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] alu_addr;
    logic [31:0] write_data;
    logic [31:0] read_data_m;
    logic        stall;
    logic        align_err;
    logic        illegal_err;
    logic        timeout_err;

    dmem_access_ctrl_if dbus ();

    dmem_access_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .alu_addr    (alu_addr),
        .write_data  (write_data),
        .dmem        (dbus.master),
        .read_data_m (read_data_m),
        .stall       (stall),
        .align_err   (align_err),
        .illegal_err (illegal_err),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] exp_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One MEM-stage instruction. ack_at = WAIT cycle carrying ack; beyond TIMEOUT means never.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int unsigned ack_at,
                             input logic [31:0] rdat);
        int unsigned stalls;
        bit          acked;
        bit          legal;
        @(negedge clock);
        mem_read   = rd;
        mem_write  = wr;
        alu_addr   = addr;
        write_data = wd;
        #1;
        check("prev_pulses_clear", {29'd0, align_err, illegal_err, timeout_err}, 32'd0);
        check("idle_req", {31'd0, dbus.dmem_req}, 32'd0);
        legal = (rd ^ wr) && (addr[1:0] == 2'b00);
        if (!legal) begin
            check("no_stall", {31'd0, stall}, 32'd0);
            @(negedge clock);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            #1;
            check("illegal_pulse", {31'd0, illegal_err}, {31'd0, rd & wr});
            check("align_pulse", {31'd0, align_err}, {31'd0, (rd ^ wr) && (addr[1:0] != 2'b00)});
            check("err_no_req", {31'd0, dbus.dmem_req}, 32'd0);
            check("err_no_stall", {31'd0, stall}, 32'd0);
            check("err_rdata_held", read_data_m, exp_rd);
            return;
        end
        stalls = {31'd0, stall};
        acked  = 1'b0;
        for (int unsigned k = 1; k <= TIMEOUT && !acked; k++) begin
            @(negedge clock);
            #1;
            stalls += {31'd0, stall};
            check("wait_req", {31'd0, dbus.dmem_req}, 32'd1);
            check("wait_we", {31'd0, dbus.dmem_we}, {31'd0, wr});
            check("wait_addr", dbus.dmem_addr, {addr[31:2], 2'b00});
            if (wr) check("wait_wdata", dbus.dmem_wdata, wd);
            if (k == ack_at) begin
                dbus.dmem_ack   = 1'b1;
                dbus.dmem_rdata = rdat;
                acked = 1'b1;
            end else begin
                dbus.dmem_rdata = $urandom;
            end
        end
        @(negedge clock);
        dbus.dmem_ack = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        #1;
        if (acked && rd) exp_rd = rdat;
        else if (!acked) exp_rd = 32'd0;
        check("done_stall", {31'd0, stall}, 32'd0);
        check("done_req", {31'd0, dbus.dmem_req}, 32'd0);
        check("done_rdata", read_data_m, exp_rd);
        check("done_timeout", {31'd0, timeout_err}, {31'd0, !acked});
        check("done_no_other_err", {30'd0, align_err, illegal_err}, 32'd0);
        check("stall_cycles", stalls, acked ? ack_at + 1 : TIMEOUT + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        exp_rd          = 32'd0;
        reset_n         = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        alu_addr        = 32'd0;
        write_data      = 32'd0;
        dbus.dmem_ack   = 1'b0;
        dbus.dmem_rdata = 32'd0;
        #1;
        check("rst_req", {31'd0, dbus.dmem_req}, 32'd0);
        check("rst_we", {31'd0, dbus.dmem_we}, 32'd0);
        check("rst_addr", dbus.dmem_addr, 32'd0);
        check("rst_wdata", dbus.dmem_wdata, 32'd0);
        check("rst_rdata", read_data_m, 32'd0);
        check("rst_flags", {28'd0, stall, align_err, illegal_err, timeout_err}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // directed cases
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 32'hCAFE_F00D);
        do_access(1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 1, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h0);
        do_access(1'b1, 1'b1, 32'h0000_0020, 32'h0, 1, 32'h0);
        do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, TIMEOUT + 1, 32'h0);
        do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, TIMEOUT, 32'hA5A5_0F0F);

        // reset during the 2nd WAIT cycle
        @(negedge clock);
        mem_read = 1'b1;
        alu_addr = 32'h0000_0080;
        @(negedge clock);
        @(negedge clock);
        #1;
        check("pre_rst_req", {31'd0, dbus.dmem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        exp_rd = 32'd0;
        check("mid_rst_req", {31'd0, dbus.dmem_req}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_rdata", read_data_m, exp_rd);
        @(negedge clock);
        mem_read = 1'b0;
        reset_n  = 1'b1;
        do_access(1'b1, 1'b0, 32'h0000_0084, 32'h0, 2, 32'h0BAD_CAFE);

        // stray ack while idle
        @(negedge clock);
        dbus.dmem_ack   = 1'b1;
        dbus.dmem_rdata = 32'hFFFF_0000;
        @(negedge clock);
        dbus.dmem_ack = 1'b0;
        #1;
        check("stray_req", {31'd0, dbus.dmem_req}, 32'd0);
        check("stray_stall", {31'd0, stall}, 32'd0);
        check("stray_rdata", read_data_m, exp_rd);

        // back-to-back load then store
        do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h1111_2222);
        do_access(1'b0, 1'b1, 32'h0000_0104, 32'h3333_4444, 1, 32'h0);

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 7);
            a  = $urandom;
            case (op)
                0:       do_access(1'b1, 1'b1, a, $urandom, 1, 32'h0);
                1:       do_access(1'b0, 1'b1, {a[31:2], 2'b10}, $urandom, 1, 32'h0);
                2, 3, 4: do_access(1'b1, 1'b0, {a[31:2], a[1:0] & {2{op[0]}}}, $urandom,
                                   $urandom_range(1, TIMEOUT + 2), $urandom);
                default: do_access(1'b0, 1'b1, {a[31:2], 2'b00}, $urandom,
                                   $urandom_range(1, TIMEOUT + 2), $urandom);
            endcase
        end

        @(negedge clock);
        #1;
        check("final_idle", {29'd0, stall, dbus.dmem_req, timeout_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
